mem_port_arbiter: RTL and testbench

//   Round-robin arbiter/sequencer sharing one 256x8 data-memory port (8-bit address, sync write, comb read)

---
 rtl/mem_port_arbiter_if.sv | 29 ++
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals shared by the data-memory port arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the memory.
interface mem_port_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   Req;
  logic [NUM_REQ-1:0]   Wr;
  logic [8*NUM_REQ-1:0] Addr;
  logic [8*NUM_REQ-1:0] WData;
  logic [NUM_REQ-1:0]   Gnt;
  logic [NUM_REQ-1:0]   Ack;
  logic [7:0]           RData;
  logic [NUM_REQ-1:0]   RValid;
  logic [7:0]           MemAddress;
  logic [7:0]           MemWriteData;
  logic                 MemWrite;
  logic                 MemRead;
  logic [7:0]           MemReadData;

  modport master (
    output Req, Wr, Addr, WData, MemReadData,
    input  Gnt, Ack, RData, RValid, MemAddress, MemWriteData, MemWrite, MemRead
  );

  modport slave (
    input  Req, Wr, Addr, WData, MemReadData,
    output Gnt, Ack, RData, RValid, MemAddress, MemWriteData, MemWrite, MemRead
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one 256x8 data-memory port among NUM_REQ requesters, with
// bounded bursts per grant and registered read-data return.
module mem_port_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned BURST_MAX = 4
) (
  input logic               Clk,
  input logic               Rst_n,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned        PtrW    = $clog2(NUM_REQ);
  localparam int unsigned        CntW    = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam logic [CntW-1:0]    CntLast = CntW'(BURST_MAX - 1);
  localparam logic [NUM_REQ-1:0] OneHot0 = NUM_REQ'(1);

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e             state_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] rvalid_q;
  logic [7:0]         rdata_q;
  logic [CntW-1:0]    cnt_q;
  logic [PtrW-1:0]    ptr_q;

  logic [PtrW-1:0] owner;
  logic [PtrW-1:0] winner;
  logic            found;
  logic            own_req;
  logic            own_wr;
  logic [7:0]      own_addr;
  logic [7:0]      own_wdata;
  logic            others_req;
  logic            access;

  // Owner's request fields, selected by the one-hot grant.
  always_comb begin
    owner     = '0;
    own_req   = 1'b0;
    own_wr    = 1'b0;
    own_addr  = '0;
    own_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_q[i]) begin
        owner     = PtrW'(i);
        own_req   = bus.Req[i];
        own_wr    = bus.Wr[i];
        own_addr  = bus.Addr[8*i +: 8];
        own_wdata = bus.WData[8*i +: 8];
      end
    end
    others_req = |(bus.Req & ~gnt_q);
    access     = (state_q == StAccess) && own_req;
  end

  // Round-robin pick: indices above the pointer first, then wrap to those at or below it.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && bus.Req[i] && (PtrW'(i) > ptr_q)) begin
        winner = PtrW'(i);
        found  = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && bus.Req[i] && (PtrW'(i) <= ptr_q)) begin
        winner = PtrW'(i);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    bus.Ack          = '0;
    bus.MemAddress   = '0;
    bus.MemWriteData = '0;
    bus.MemWrite     = 1'b0;
    bus.MemRead      = 1'b0;
    if (access) begin
      bus.Ack          = gnt_q;
      bus.MemAddress   = own_addr;
      bus.MemWriteData = own_wdata;
      bus.MemWrite     = own_wr;
      bus.MemRead      = ~own_wr;
    end
  end

  assign bus.Gnt    = gnt_q;
  assign bus.RData  = rdata_q;
  assign bus.RValid = rvalid_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= StIdle;
      gnt_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
      ptr_q    <= PtrW'(NUM_REQ - 1);
    end else begin
      rvalid_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (|bus.Req) begin
            gnt_q   <= OneHot0 << winner;
            cnt_q   <= '0;
            state_q <= StAccess;
          end
        end
        StAccess: begin
          if (!own_req) begin
            gnt_q   <= '0;
            ptr_q   <= owner;
            state_q <= StIdle;
          end else begin
            if (!own_wr) begin
              rdata_q  <= bus.MemReadData;
              rvalid_q <= gnt_q;
            end
            // A sole requester keeps the port; the count saturates instead of wrapping.
            if ((cnt_q == CntLast) && others_req) begin
              gnt_q   <= '0;
              ptr_q   <= owner;
              state_q <= StIdle;
            end else if (cnt_q != CntLast) begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stimulus pushes expected accesses/read returns into
// queues, a negedge monitor pops and compares whenever Ack or RValid is presented.
module tb_mem_port_arbiter;
  localparam int unsigned NumReq = 4;

  logic Clk;
  logic Rst_n;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  mem_port_arbiter_if #(.NUM_REQ(NumReq)) bus ();

  mem_port_arbiter #(
    .NUM_REQ  (NumReq),
    .BURST_MAX(4)
  ) dut (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .bus  (bus)
  );

  // Memory model: sync write, comb read, plus a backdoor port used only while idle.
  logic [7:0] mem [256];
  logic       bd_we;
  logic [7:0] bd_addr;
  logic [7:0] bd_data;

  always @(posedge Clk) begin
    if (bus.MemWrite) mem[bus.MemAddress] <= bus.MemWriteData;
    else if (bd_we)   mem[bd_addr] <= bd_data;
  end
  assign bus.MemReadData = mem[bus.MemAddress];

  typedef struct packed {
    logic [3:0] ack;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
  } ack_t;

  typedef struct packed {
    logic [3:0] v;
    logic [7:0] d;
  } rv_t;

  ack_t ack_q[$];
  rv_t  rv_q[$];
  int   checks;
  int   failures;
  int   wr_cycles;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_acc(input int o, input logic wr, input logic [7:0] a, input logic [7:0] d,
                          input logic [7:0] rd);
    ack_t e;
    rv_t  r;
    e.ack   = 4'(1 << o);
    e.wr    = wr;
    e.addr  = a;
    e.wdata = d;
    ack_q.push_back(e);
    if (!wr) begin
      r.v = 4'(1 << o);
      r.d = rd;
      rv_q.push_back(r);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic bd_write(input logic [7:0] a, input logic [7:0] d);
    bd_addr = a;
    bd_data = d;
    bd_we   = 1'b1;
    @(posedge Clk);
    #1;
    bd_we = 1'b0;
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, "_gnt"}, 32'(bus.Gnt), 0);
    chk({name, "_ack"}, 32'(bus.Ack), 0);
    chk({name, "_rvalid"}, 32'(bus.RValid), 0);
    chk({name, "_mem"}, 32'({bus.MemWrite, bus.MemRead, bus.MemAddress, bus.MemWriteData}), 0);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst_n = 1'b0;
    repeat (2) @(negedge Clk);
    chk_reset_state("reset");
    chk("reset_rdata", 32'(bus.RData), 0);
    Rst_n = 1'b1;
    tick();
  endtask

  // One access from requester i; Req dropped right after the acknowledging edge.
  task automatic req_once(input int i, input logic wr, input logic [7:0] a, input logic [7:0] d);
    logic seen;
    seen = 1'b0;
    bus.Wr[i]          = wr;
    bus.Addr[i*8 +: 8]  = a;
    bus.WData[i*8 +: 8] = d;
    bus.Req[i]         = 1'b1;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge Clk);
      if (bus.Ack[i]) seen = 1'b1;
    end
    chk("req_once_ack_seen", 32'(seen), 1);
    @(posedge Clk);
    #1;
    bus.Req[i] = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && (ack_q.size() != 0 || rv_q.size() != 0); n++) tick();
    chk("ack_queue_empty", 32'(ack_q.size()), 0);
    chk("rvalid_queue_empty", 32'(rv_q.size()), 0);
  endtask

  // Monitor: invariants every cycle, scoreboard pops when the DUT presents Ack/RValid.
  initial begin : monitor
    ack_t ea;
    rv_t  er;
    forever begin
      @(negedge Clk);
      if (bus.MemWrite) wr_cycles++;
      chk("no_write_and_read", 32'(bus.MemWrite & bus.MemRead), 0);
      chk("ack_onehot0", 32'($onehot0(bus.Ack)), 1);
      if (bus.Ack == '0) begin
        chk("strobes_without_ack",
            32'({bus.MemWrite, bus.MemRead, bus.MemAddress, bus.MemWriteData}), 0);
      end else if (ack_q.size() == 0) begin
        chk("ack_unexpected", 32'(bus.Ack), 0);
      end else begin
        ea = ack_q.pop_front();
        chk("ack_owner", 32'(bus.Ack), 32'(ea.ack));
        chk("ack_memwrite", 32'(bus.MemWrite), 32'(ea.wr));
        chk("ack_memread", 32'(bus.MemRead), 32'(!ea.wr));
        chk("ack_address", 32'(bus.MemAddress), 32'(ea.addr));
        if (ea.wr) chk("ack_wdata", 32'(bus.MemWriteData), 32'(ea.wdata));
      end
      if (bus.RValid != '0) begin
        if (rv_q.size() == 0) begin
          chk("rvalid_unexpected", 32'(bus.RValid), 0);
        end else begin
          er = rv_q.pop_front();
          chk("rvalid_owner", 32'(bus.RValid), 32'(er.v));
          chk("rdata", 32'(bus.RData), 32'(er.d));
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [3:0] exp_gnt;
    int         wr0;
    checks    = 0;
    failures  = 0;
    wr_cycles = 0;
    Rst_n     = 1'b0;
    bd_we     = 1'b0;
    bd_addr   = '0;
    bd_data   = '0;
    bus.Req   = '0;
    bus.Wr    = '0;
    bus.Addr  = '0;
    bus.WData = '0;

    // Preload while held in reset (no strobes possible).
    bd_write(8'h10, 8'hA5);
    for (int i = 0; i < 4; i++) bd_write(8'(8'h40 + i), 8'(8'h50 + i));
    @(negedge Clk);
    chk_reset_state("initial_reset");
    chk("initial_reset_rdata", 32'(bus.RData), 0);
    Rst_n = 1'b1;
    tick();

    // 1: single read by requester 0, exact latency.
    push_acc(0, 1'b0, 8'h10, 8'h00, 8'hA5);
    bus.Addr[7:0] = 8'h10;
    bus.Req       = 4'b0001;
    @(negedge Clk);
    chk("t1_idle_gnt", 32'(bus.Gnt), 0);
    @(negedge Clk);
    chk("t1_gnt", 32'(bus.Gnt), 32'h1);
    chk("t1_ack", 32'(bus.Ack), 32'h1);
    chk("t1_memread", 32'(bus.MemRead), 1);
    @(posedge Clk);
    #1;
    bus.Req = '0;
    @(negedge Clk);
    chk("t1_rvalid", 32'(bus.RValid), 32'h1);
    chk("t1_rdata", 32'(bus.RData), 32'hA5);
    drain();

    // 2: single write by requester 1, then read it back.
    wr0 = wr_cycles;
    push_acc(1, 1'b1, 8'h20, 8'h3C, 8'h00);
    req_once(1, 1'b1, 8'h20, 8'h3C);
    repeat (3) tick();
    chk("t2_write_cycles", 32'(wr_cycles - wr0), 1);
    push_acc(1, 1'b0, 8'h20, 8'h00, 8'h3C);
    req_once(1, 1'b0, 8'h20, 8'h00);
    @(negedge Clk);
    chk("t2_readback_rvalid", 32'(bus.RValid), 32'h2);
    chk("t2_readback_rdata", 32'(bus.RData), 32'h3C);
    drain();

    // 3: all four requesting: bursts of 4 with one idle cycle per handover.
    do_reset();
    bus.Wr   = '0;
    bus.Addr = {8'h43, 8'h42, 8'h41, 8'h40};
    for (int r = 0; r < 5; r++)
      for (int b = 0; b < 4; b++) push_acc(r % 4, 1'b0, 8'(8'h40 + r % 4), 8'h00, 8'(8'h50 + r % 4));
    bus.Req = 4'b1111;
    for (int k = 0; k < 25; k++) begin
      @(negedge Clk);
      exp_gnt = (k % 5 == 0) ? 4'b0000 : 4'(1 << ((k / 5) % 4));
      chk("t3_gnt_sequence", 32'(bus.Gnt), 32'(exp_gnt));
    end
    @(posedge Clk);
    #1;
    bus.Req = '0;
    drain();

    // 4: sole requester 2 is never forced out.
    for (int n = 0; n < 10; n++) push_acc(2, 1'b0, 8'h42, 8'h00, 8'h52);
    bus.Req = 4'b0100;
    @(negedge Clk);
    for (int n = 0; n < 10; n++) begin
      @(negedge Clk);
      chk("t4_gnt_held", 32'(bus.Gnt), 32'h4);
      chk("t4_ack", 32'(bus.Ack), 32'h4);
    end
    @(posedge Clk);
    #1;
    bus.Req = '0;
    repeat (3) tick();
    drain();

    // 5: owner 0 drops mid-burst with requester 3 pending.
    push_acc(0, 1'b0, 8'h40, 8'h00, 8'h50);
    push_acc(0, 1'b0, 8'h40, 8'h00, 8'h50);
    push_acc(3, 1'b0, 8'h43, 8'h00, 8'h53);
    bus.Req = 4'b0001;
    @(negedge Clk);
    @(negedge Clk);
    chk("t5_gnt0", 32'(bus.Gnt), 32'h1);
    @(negedge Clk);
    @(posedge Clk);
    #1;
    bus.Req = 4'b1000;
    @(negedge Clk);
    chk("t5_abort_ack", 32'(bus.Ack), 0);
    chk("t5_abort_strobes", 32'({bus.MemWrite, bus.MemRead}), 0);
    @(negedge Clk);
    chk("t5_idle_gnt", 32'(bus.Gnt), 0);
    @(negedge Clk);
    chk("t5_gnt3", 32'(bus.Gnt), 32'h8);
    chk("t5_ack3", 32'(bus.Ack), 32'h8);
    @(posedge Clk);
    #1;
    bus.Req = '0;
    repeat (3) tick();
    drain();

    // 6: asynchronous reset mid-burst, then requester 0 wins first.
    push_acc(1, 1'b0, 8'h41, 8'h00, 8'h51);
    ack_q.push_back('{ack: 4'b0010, wr: 1'b0, addr: 8'h41, wdata: 8'h00});
    bus.Req = 4'b0110;
    @(negedge Clk);
    @(negedge Clk);
    chk("t6_ack_first", 32'(bus.Ack), 32'h2);
    @(negedge Clk);
    chk("t6_ack_second", 32'(bus.Ack), 32'h2);
    #2;
    Rst_n = 1'b0;
    #1;
    chk_reset_state("t6_async_reset");
    bus.Req = 4'b0111;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    push_acc(0, 1'b0, 8'h40, 8'h00, 8'h50);
    @(negedge Clk);
    chk("t6_post_reset_gnt", 32'(bus.Gnt), 32'h1);
    chk("t6_post_reset_ack", 32'(bus.Ack), 32'h1);
    @(posedge Clk);
    #1;
    bus.Req = '0;
    repeat (3) tick();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
